// File: rtl/regfile_mp_pkg.sv
// Shared types and sizing helpers for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  function automatic int depthOf(input int addrW);
    return 1 << addrW;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Writeback/operand-fetch bus of the register file: one write port, NUM_RD read ports.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     en;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     init_busy;

  modport master (
    output en, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, init_busy
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, init_busy
  );
endinterface

// File: rtl/regfile_mp_rd_port.sv
// One registered read port: hardwired-zero check, write-first bypass, output register.
module regfile_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdStrobe,
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] rdData
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdData <= '0;
    end else if (rdStrobe) begin
      if (ZERO_REG != 0 && rdAddr == '0) begin
        rdData <= '0;
      end else if (wrEn && wrAddr == rdAddr) begin
        rdData <= wrData;
      end else begin
        rdData <= memData;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with a post-reset clear sweep and NUM_RD registered read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = depthOf(ADDR_W);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W:0]   clrPtr;
  logic              initBusy;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready;
  logic              wrAccept;

  assign ready    = (state == ST_READY);
  assign wrAccept = ready && bus.en && bus.wr_en &&
                    !(ZERO_REG != 0 && bus.wr_addr == '0);
  assign bus.init_busy = initBusy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clrPtr   <= '0;
      initBusy <= 1'b1;
    end else if (state == ST_CLEAR) begin
      clrPtr <= clrPtr + 1'b1;
      if (clrPtr == LAST_PTR) begin
        state    <= ST_READY;
        initBusy <= 1'b0;
      end
    end
  end

  // mem has no reset; the sweep is the only way entries become defined
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[clrPtr[ADDR_W-1:0]] <= '0;
      end else if (wrAccept) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : gRd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign bus.rd_data[p*DATA_W +: DATA_W] = data;

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) uPort (
      .clk      (clk),
      .rst      (rst),
      .rdStrobe (ready && bus.en && bus.rd_en[p]),
      .rdAddr   (addr),
      .wrEn     (bus.wr_en),
      .wrAddr   (bus.wr_addr),
      .wrData   (bus.wr_data),
      .memData  (mem[addr]),
      .rdData   (data)
    );
  end

endmodule
